itcm_loader: RTL
================

# itcm_loader

Boot-time instruction loader sitting between the cpu and the srams ITCM port. After reset it holds the cpu and accepts a byte stream carrying a program image. It assembles the bytes into 32-bit words, writes them into ITCM from word 0, and checks a trailer checksum. It then releases the cpu and passes the cpu's ITCM port straight through to the sram.

## Interface
- AW, default `ITCM_RAM_AW`: ITCM word-address width; depth is 2^AW words.
- DW, default `ITCM_RAM_DW`: ITCM data width; must be 32.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte-stream ready; a byte transfers when s_valid && s_ready.
- reload  in  1  single-cycle request to restart loading from DONE or ERR.
- cpu_hold  out  1  high keeps the cpu in reset.
- load_done  out  1  image loaded and checksum good.
- load_err  out  1  image rejected.
- cpu_itcm_we / cpu_itcm_addr[AW] / cpu_itcm_din[DW] / cpu_itcm_wem  in  cpu-side ITCM request.
- cpu_itcm_dout  out  DW  cpu-side read data, always equal to itcm_ram_dout.
- itcm_ram_we / itcm_ram_addr[AW] / itcm_ram_din[DW] / itcm_ram_wem  out  to srams.
- itcm_ram_dout  in  DW  from srams.

## Operation
- **Image format** (all fields little-endian, byte 0 first):
  - 32-bit word count N.
  - N 32-bit data words.
  - 32-bit checksum, equal to the sum of the data words mod 2^32.
- **FSM states:** HDR, DATA, CSUM, DONE, ERR. Reset enters HDR.
- **Byte assembly:**
  - A 2-bit byte counter places each accepted byte into shift register bits [8k+7:8k].
  - The 4th accepted byte completes the word.
- **HDR:**
  - On completing the word, N is latched and the word index and checksum are cleared.
  - N > 2^AW → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- **DATA:**
  - Each completed word is added to the checksum and written at the word index; the index then increments.
  - After word N-1 → CSUM.
- **CSUM:** on completing the word, a match with the accumulated checksum → DONE, a mismatch → ERR.
- **DONE / ERR:** no further bytes are accepted; reload → HDR, clearing the counters, checksum, load_done and load_err.
- **s_ready:** 1 in HDR, DATA and CSUM; 0 in DONE and ERR. Bytes are never stalled while loading.
- **Flags:**
  - cpu_hold = (state != DONE).
  - load_done = (state == DONE).
  - load_err = (state == ERR).
- **ITCM mux:**
  - In DONE, the itcm_ram_* outputs equal the cpu_itcm_* inputs combinationally.
  - In all other states the loader drives them: we and wem are 1 for exactly one cycle per data word, and 0 otherwise.

## Timing
- **Reset values:**
  - state HDR, s_ready 1, cpu_hold 1, load_done 0, load_err 0.
  - itcm_ram_we 0, itcm_ram_wem 0, itcm_ram_addr 0, itcm_ram_din 0.
- **Write latency:** a data word's write is registered. itcm_ram_we is high in the cycle after its 4th byte is accepted, with addr = word index and din = assembled word.
- **Back-to-back writes:** successive word writes are at least 4 cycles apart, so a write never collides with assembly.
- **Release:**
  - DONE is entered the cycle after the trailer's 4th byte.
  - cpu_hold falls in that same cycle.
  - The last data word's write has always completed by then, because at least 4 cycles separate it from the trailer.
- **reload:**
  - Sampled only in DONE or ERR; ignored elsewhere.
  - cpu_hold rises the cycle after the reload pulse.
- **Reset mid-load:**
  - All state is cleared immediately and asynchronously; we drops with no write in progress.
  - Partial ITCM contents are left as written.
- **Arithmetic:**
  - The word index is AW+1 bits, so N = 2^AW is legal.
  - The checksum wraps mod 2^32.
  - The N comparison is done on the full 32 bits.

## Structure
- The shared defines header provides ITCM_RAM_AW and ITCM_RAM_DW.
- Local constants in the module: the state encoding (3 bits) and the byte-per-word count of 4.
- One sub-module is natural: `byte_word_packer`.
  - Holds the 2-bit counter and 32-bit shift register.
  - Emits a one-cycle word_valid together with the word.
- The FSM, checksum and mux live in itcm_loader.

## Test plan
- **Normal load:** stream N=2, words 0x00000013 and 0xDEADBEEF, checksum 0xDEADBF02.
  - ITCM writes go to addr 0 and addr 1 with those values.
  - load_done=1, cpu_hold=0, the mux passes cpu_itcm_addr through.
- **Bad checksum:** the same image with trailer 0x00000000.
  - Two writes occur, then load_err=1, cpu_hold=1, s_ready=0.
- **Oversize header:** N = 2^AW + 1.
  - ERR the cycle after the 4th header byte, with no ITCM write.
- **Empty image:** N=0, checksum 0 → DONE with zero writes.
- **Gapped stream:** random s_valid gaps.
  - Each write occurs exactly one cycle after its word's 4th byte; the byte order is little-endian.
- **Mid-load reset and reload:**
  - Assert rst_n=0 after 6 bytes: outputs return to their reset values immediately.
  - A following full load succeeds.
  - In ERR, a reload pulse returns to HDR and a subsequent good image reaches DONE.

Source files
------------

// File: rtl/itcm_loader_pkg.sv
// Shared constants and types for the boot-time ITCM loader.
package itcm_loader_pkg;

  localparam int unsigned ITCM_RAM_AW    = 10;
  localparam int unsigned ITCM_RAM_DW    = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StHdr  = 3'd0,
    StData = 3'd1,
    StCsum = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses with the 4th byte.
module byte_word_packer
  import itcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (byte_valid) begin
      sh_d[{cnt_q, 3'b000} +: 8] = byte_data;
    end
  end

  // Word is presented combinationally in the same cycle its last byte is accepted.
  assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = sh_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/itcm_loader.sv
// Boot loader: streams a checksummed image into ITCM while holding the cpu, then
// hands the ITCM port over to the cpu.
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int unsigned AW = ITCM_RAM_AW,
  parameter int unsigned DW = ITCM_RAM_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  input  logic              cpu_itcm_we,
  input  logic [AW-1:0]     cpu_itcm_addr,
  input  logic [DW-1:0]     cpu_itcm_din,
  input  logic [DW/8-1:0]   cpu_itcm_wem,
  output logic [DW-1:0]     cpu_itcm_dout,
  output logic              itcm_ram_we,
  output logic [AW-1:0]     itcm_ram_addr,
  output logic [DW-1:0]     itcm_ram_din,
  output logic [DW/8-1:0]   itcm_ram_wem,
  input  logic [DW-1:0]     itcm_ram_dout
);

  localparam int unsigned MW = DW / 8;
  // Widened so that N == 2^AW is representable and the compare spans all 32 bits of N.
  localparam logic [32:0] MaxWords = 33'd1 << AW;

  loader_state_e state_q, state_d;
  logic [31:0]   n_q, n_d;
  logic [AW:0]   idx_q, idx_d;
  logic [31:0]   csum_q, csum_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          clear;
  logic          word_valid;
  logic [31:0]   word;

  assign s_ready = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .byte_valid (s_valid && s_ready),
    .byte_data  (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    clear   = 1'b0;
    case (state_q)
      StHdr: begin
        if (word_valid) begin
          n_d    = word;
          idx_d  = '0;
          csum_d = '0;
          if ({1'b0, word} > MaxWords) begin
            state_d = StErr;
          end else if (word == 32'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_valid) begin
          csum_d = csum_q + word;
          we_d   = 1'b1;
          addr_d = idx_q[AW-1:0];
          din_d  = word;
          idx_d  = idx_q + 1'b1;
          if (32'(idx_d) == n_q) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (word_valid) begin
          state_d = (word == csum_q) ? StDone : StErr;
        end
      end
      StDone, StErr: begin
        if (reload) begin
          state_d = StHdr;
          n_d     = '0;
          idx_d   = '0;
          csum_d  = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHdr;
      n_q     <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign cpu_hold      = (state_q != StDone);
  assign load_done     = (state_q == StDone);
  assign load_err      = (state_q == StErr);
  assign cpu_itcm_dout = itcm_ram_dout;

  always_comb begin
    if (state_q == StDone) begin
      itcm_ram_we   = cpu_itcm_we;
      itcm_ram_addr = cpu_itcm_addr;
      itcm_ram_din  = cpu_itcm_din;
      itcm_ram_wem  = cpu_itcm_wem;
    end else begin
      itcm_ram_we   = we_q;
      itcm_ram_addr = addr_q;
      itcm_ram_din  = din_q;
      itcm_ram_wem  = {MW{we_q}};
    end
  end

endmodule
